// File: rtl/i2s_speaker_tx_if.sv
// Sample bus between the note generator and the I2S speaker transmitter.
// The generator (master) holds a stereo sample pair plus mute/volume steady;
// the transmitter (slave) pulses sample_ack when it has latched them.
interface i2s_speaker_tx_if;
  logic [15:0] audio_in_left;
  logic [15:0] audio_in_right;
  logic [2:0]  vol;
  logic        mute;
  logic        sample_ack;

  modport master (
    output audio_in_left,
    output audio_in_right,
    output vol,
    output mute,
    input  sample_ack
  );

  modport slave (
    input  audio_in_left,
    input  audio_in_right,
    input  vol,
    input  mute,
    output sample_ack
  );
endinterface

// File: rtl/i2s_speaker_tx.sv
// I2S transmitter for the Pmod I2S DAC.
// A free-running 9-bit counter produces MCLK (clk/4), SCK (clk/16) and
// LRCK (clk/512) straight from register bits, so the pins never glitch.
// Once per 512-cycle frame the sample pair is latched (with mute and
// volume applied) into shadow registers, which are then shifted out
// MSB first with the standard I2S one-bit delay after each LRCK edge.
module i2s_speaker_tx #(
  parameter int SAMPLE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  i2s_speaker_tx_if.slave  bus,
  output logic             audio_mclk,
  output logic             audio_lrck,
  output logic             audio_sck,
  output logic             audio_sdin
);

  logic [8:0]          cnt;
  logic [SAMPLE_W-1:0] shadow_l;
  logic [SAMPLE_W-1:0] shadow_r;
  logic [SAMPLE_W-1:0] proc_l;
  logic [SAMPLE_W-1:0] proc_r;
  logic [4:0]          next_slot;
  logic [4:0]          idx_l;
  logic [4:0]          idx_r;
  logic                next_bit;
  logic                sample_ack_q;

  // Mute forces silence; otherwise attenuate by 7-vol binary steps while
  // keeping the sign, so vol=7 passes the sample through unchanged.
  function automatic logic [SAMPLE_W-1:0] attenuate(
    input logic [SAMPLE_W-1:0] x,
    input logic [2:0]          v,
    input logic                m
  );
    logic [2:0] shamt;
    shamt = 3'd7 - v;
    if (m) return '0;
    return $signed(x) >>> shamt;
  endfunction

  assign proc_l = attenuate(bus.audio_in_left,  bus.vol, bus.mute);
  assign proc_r = attenuate(bus.audio_in_right, bus.vol, bus.mute);

  // Frame counter: every output clock and the slot index derive from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + 9'd1;
  end

  assign audio_mclk = cnt[1];
  assign audio_sck  = cnt[3];
  assign audio_lrck = cnt[8];

  // Latch the processed sample pair once per frame, on the wrap edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_l <= '0;
      shadow_r <= '0;
    end else if (cnt == 9'd511) begin
      shadow_l <= proc_l;
      shadow_r <= proc_r;
    end
  end

  // Pick the bit for the slot about to start; slot 0 carries the previous
  // frame's right-channel LSB because of the one-bit I2S delay.
  always_comb begin
    next_slot = cnt[8:4] + 5'd1;
    idx_l     = 5'd16 - next_slot;
    idx_r     = 5'd0 - next_slot;
    next_bit  = 1'b0;
    if (next_slot == 5'd0)
      next_bit = shadow_r[0];
    else if (next_slot <= 5'd16)
      next_bit = shadow_l[idx_l[3:0]];
    else
      next_bit = shadow_r[idx_r[3:0]];
  end

  // Serial data changes only on SCK falling edges (cnt[3:0] 15 -> 0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    audio_sdin <= 1'b0;
    else if (cnt[3:0] == 4'hF)  audio_sdin <= next_bit;
  end

  // Acknowledge is high for the single cycle after the capture edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sample_ack_q <= 1'b0;
    else     sample_ack_q <= (cnt == 9'd511);
  end

  assign bus.sample_ack = sample_ack_q;

endmodule
